cpu_controller: RTL and testbench
=================================

# cpu_controller

Sequencing controller for the 8-bit accumulator CPU. It drives the ALU, instruction register, program counter, accumulator and memory bus through a fixed 8-phase fetch/execute cycle. Per-phase control strobes come from the current phase, the 3-bit `opcode` held in the instruction register, and the ALU `zero` flag. A sticky halt state stops the cycle until reset.

## Interface
- No parameters. Widths are fixed by the 8-bit datapath and 3-bit opcode.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces phase INST_ADDR and clears halted.
- `opcode` in 3: instruction register opcode; stable from INST_LOAD+1 to end of cycle.
- `zero` in 1: ALU zero flag (accumulator == 0).
- `sel` out 1: address mux; 1 = PC, 0 = IR operand address.
- `rd` out 1: memory read enable.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: program counter increment.
- `ld_pc` out 1: program counter load (jump).
- `ld_ac` out 1: accumulator load from `alu_out`.
- `wr` out 1: memory write strobe.
- `data_e` out 1: accumulator-to-bus driver enable.
- `halt` out 1: CPU halted.
- `phase` out 3: current phase, for debug and bench.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- Phases, one clock each, advancing 0→1→…→7→0: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7).
- Output decode (all signals not listed are 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc if opcode≠HLT; halt if opcode=HLT.
  - OP_FETCH: rd if ALUOP.
  - ALU_OP: rd if ALUOP; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
  - STORE: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
- HLT: in OP_ADDR with opcode=HLT, the next state is HALTED. HALTED is sticky and is left only by reset.
  - In HALTED: halt=1, all other strobes 0, `phase` holds 4.
- SKZ with zero=0, and any opcode not named for a phase, produces no strobes in that phase.

## Timing
- Strobes are combinational from the registered phase/halted state plus `opcode`/`zero`. There are no flops on outputs.
- Each instruction takes exactly 8 cycles. The PC advances once in OP_ADDR, plus once more in ALU_OP for a taken SKZ.
- `zero` is sampled only in ALU_OP. In all other phases it is ignored.
- Reset, asserted at any time (including mid-instruction or while halted):
  - Phase goes to INST_ADDR and halted clears immediately, without waiting for a clock.
  - Outputs during reset: sel=1, all others 0, phase=0.
- Release: the first rising edge after reset deasserts moves the phase to INST_FETCH.
- Wrap-around: STORE→INST_ADDR, with no idle cycle between instructions.
- Only one of `wr` and `rd` is ever high in a given cycle. `wr` is never asserted without `data_e`.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants (HLT…JMP).
  - Phase encodings (INST_ADDR…STORE).
  - Datapath width constant (8).
- Both this block and the ALU use `cpu_pkg`.
- One natural sub-module, `ctrl_decode`: purely combinational map from (phase, halted, opcode, zero) to the 9 strobes.
- The top keeps the 3-bit phase counter and the halted flop.

## Test plan
- Reset: hold reset 2 cycles → phase=0, sel=1, other strobes 0. Release → phase sequence 1,2,…,7,0 on successive edges.
- ADD (opcode=2), full 8-phase pass:
  - rd=1 in phases 1,2,3,5,6,7.
  - ld_ir=1 in phases 2,3.
  - inc_pc=1 in phase 4 only.
  - ld_ac=1 in phase 7 only.
  - wr, data_e, ld_pc stay 0.
- STO (opcode=6): data_e=1 in phases 6,7; wr=1 in phase 7 only; rd=0 in phases 5–7.
- SKZ (opcode=1):
  - zero=1 → inc_pc=1 in phases 4 and 6.
  - Repeat with zero=0 → inc_pc=1 in phase 4 only.
- JMP (opcode=7): ld_pc=1 in phases 6,7; inc_pc=1 in phase 4; ld_ac=0 throughout.
- HLT (opcode=0):
  - Phase 4 → halt=1, inc_pc=0. Then 20 cycles with halt=1, phase=4, all other strobes 0.
  - Assert reset asynchronously mid-cycle → halt drops immediately, phase=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, phase encodings,
// datapath width and an ALU-opcode classifier used by control and ALU.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned PHASE_W = 3;

  localparam logic [OP_W-1:0] OP_HLT = 3'd0;
  localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_LDA = 3'd5;
  localparam logic [OP_W-1:0] OP_STO = 3'd6;
  localparam logic [OP_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes whose result is written back to the accumulator from memory data.
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode for the CPU controller.
// Inputs : phase (current phase), halted (sticky halt state), opcode, zero.
// Outputs: sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt.
module ctrl_decode
  import cpu_pkg::*;
(
  input  phase_e          phase,
  input  logic            halted,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            ld_ac,
  output logic            wr,
  output logic            data_e,
  output logic            halt
);

  logic aluop;
  assign aluop = is_aluop(opcode);

  // Phase-by-phase strobe map; halted overrides everything but halt.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != OP_HLT);
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU.
// Holds the 3-bit phase counter and the sticky halted flag; strobes are
// decoded combinationally in ctrl_decode.
// Inputs : clk, reset (async, active-high), opcode[2:0], zero.
// Outputs: sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase[2:0].
module cpu_controller
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: advance every cycle; HLT in OP_ADDR freezes at phase 4.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((phase_q == OP_ADDR) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  assign phase = PHASE_W'(phase_q);

  ctrl_decode u_decode (
    .phase  (phase_q),
    .halted (halted_q),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the stimulus process pushes hand-computed
// expected strobes/phase each cycle; a monitor on the falling edge pops and compares.
// Strobe vector order: {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  typedef struct {
    string      name;
    logic [2:0] ph;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Hand-written strobe patterns.
  localparam logic [8:0] S_SEL   = 9'b100000000;
  localparam logic [8:0] S_SR    = 9'b110000000;
  localparam logic [8:0] S_SRI   = 9'b111000000;
  localparam logic [8:0] S_INC   = 9'b000100000;
  localparam logic [8:0] S_NONE  = 9'b000000000;
  localparam logic [8:0] S_RD    = 9'b010000000;
  localparam logic [8:0] S_RDAC  = 9'b010001000;
  localparam logic [8:0] S_DE    = 9'b000000010;
  localparam logic [8:0] S_WRDE  = 9'b000000110;
  localparam logic [8:0] S_LDPC  = 9'b000010000;
  localparam logic [8:0] S_HALT  = 9'b000000001;

  localparam logic [71:0] T_ADD  = {S_SEL, S_SR, S_SRI, S_SRI, S_INC, S_RD,   S_RD,   S_RDAC};
  localparam logic [71:0] T_STO  = {S_SEL, S_SR, S_SRI, S_SRI, S_INC, S_NONE, S_DE,   S_WRDE};
  localparam logic [71:0] T_SKZ1 = {S_SEL, S_SR, S_SRI, S_SRI, S_INC, S_NONE, S_INC,  S_NONE};
  localparam logic [71:0] T_SKZ0 = {S_SEL, S_SR, S_SRI, S_SRI, S_INC, S_NONE, S_NONE, S_NONE};
  localparam logic [71:0] T_JMP  = {S_SEL, S_SR, S_SRI, S_SRI, S_INC, S_NONE, S_LDPC, S_LDPC};
  localparam logic [71:0] T_HLT  = {S_SEL, S_SR, S_SRI, S_SRI, S_HALT, S_HALT, S_HALT, S_HALT};

  cpu_controller dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Monitor: compares one expected entry per falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s strobes: got %b expected %b (t=%0t)", e.name, got, e.v, $time);
      end
      checks++;
      if (phase !== e.ph) begin
        errors++;
        $display("FAIL %s phase: got %0d expected %0d (t=%0t)", e.name, phase, e.ph, $time);
      end
      checks++;
      if ((wr && rd) || (wr && !data_e)) begin
        errors++;
        $display("FAIL %s bus_rule: wr=%b rd=%b data_e=%b expected no wr with rd or without data_e",
                 e.name, wr, rd, data_e);
      end
    end
  end

  task automatic push(input string nm, input logic [2:0] ph, input logic [8:0] v);
    exp_t e;
    e.name = nm;
    e.ph   = ph;
    e.v    = v;
    sb.push_back(e);
  endtask

  // Push this cycle's expectation, then step to just after the next rising edge.
  task automatic chk_cycle(input string nm, input logic [2:0] ph, input logic [8:0] v);
    push(nm, ph, v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [2:0] op, input logic z,
                           input logic [71:0] tbl);
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      chk_cycle(nm, 3'(i), tbl[71-9*i -: 9]);
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    chk_cycle("reset_hold", 3'd0, S_SEL);
    chk_cycle("reset_hold", 3'd0, S_SEL);
    reset = 1'b0;

    run_instr("add",    3'd2, 1'b1, T_ADD);
    run_instr("sto",    3'd6, 1'b0, T_STO);
    run_instr("skz_z1", 3'd1, 1'b1, T_SKZ1);
    run_instr("skz_z0", 3'd1, 1'b0, T_SKZ0);
    run_instr("jmp",    3'd7, 1'b1, T_JMP);

    // HLT: phases 0..4, then sticky halted regardless of opcode/zero.
    opcode = 3'd0;
    zero   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_cycle("hlt", 3'(i), T_HLT[71-9*i -: 9]);
    end
    opcode = 3'd2;
    zero   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk_cycle("halted", 3'd4, S_HALT);
    end

    // Asynchronous reset mid-cycle: effect visible before the next rising edge.
    #2;
    reset = 1'b1;
    push("async_reset", 3'd0, S_SEL);
    @(posedge clk);
    #1;
    chk_cycle("reset_hold2", 3'd0, S_SEL);
    reset = 1'b0;

    run_instr("add_after_reset", 3'd3, 1'b0, T_ADD);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
